// File: rtl/prince_sbox_inv_ctrl.sv
// Streams a three-share PRINCE state through a pipelined masked inverse S-box,
// one nibble per cycle, and reassembles the returned shares into the result state.
module prince_sbox_inv_ctrl #(
    parameter int LAT  = 4,
    parameter int NNIB = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_valid,
    output logic        start_ready,
    input  logic [63:0] sh1_in,
    input  logic [63:0] sh2_in,
    input  logic [63:0] sh3_in,
    input  logic        rnd_valid,
    output logic        rnd_ready,
    input  logic [42:0] rnd,
    output logic [3:0]  sbox_in1,
    output logic [3:0]  sbox_in2,
    output logic [3:0]  sbox_in3,
    output logic [42:0] sbox_r,
    output logic [3:0]  sbox_klmn_in1,
    output logic [5:0]  sbox_klmn_in2,
    input  logic [5:0]  sbox_klmn_out1,
    input  logic [3:0]  sbox_out1,
    input  logic [3:0]  sbox_out2,
    input  logic [3:0]  sbox_out3,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] sh1_out,
    output logic [63:0] sh2_out,
    output logic [63:0] sh3_out,
    output logic        busy
);
    localparam int IW = (NNIB > 1) ? $clog2(NNIB) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
    state_t state, state_nxt;

    logic [63:0]          sh1_q, sh2_q, sh3_q;
    logic [63:0]          res1, res2, res3;
    logic [4:0]           issue_cnt, col_cnt;
    logic [5:0]           klmn_fb;
    logic [LAT:1]         tag_v;
    logic [LAT:1][IW-1:0] tag_idx;

    logic          start_acc, issue, collect, last_issue, col_done;
    logic [IW+1:0] issue_bit, col_bit;

    assign start_acc  = (state == IDLE) && start_valid;
    assign issue      = (state == ISSUE) && rnd_valid && (issue_cnt != 5'(NNIB));
    assign collect    = tag_v[LAT];
    assign last_issue = issue && (issue_cnt == 5'(NNIB - 1));
    // Looks one collect ahead so DONE is entered the cycle after the count lands.
    assign col_done   = (col_cnt == 5'(NNIB)) || (collect && (col_cnt == 5'(NNIB - 1)));
    assign issue_bit  = {issue_cnt[IW-1:0], 2'b00};
    assign col_bit    = {tag_idx[LAT], 2'b00};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_valid) state_nxt = ISSUE;
            ISSUE:   if (last_issue)  state_nxt = DRAIN;
            DRAIN:   if (col_done)    state_nxt = DONE;
            DONE:    if (out_ready)   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        start_ready = (state == IDLE);
        rnd_ready   = (state == ISSUE);
        out_valid   = (state == DONE);
        busy        = (state != IDLE);
        sbox_in1    = '0;
        sbox_in2    = '0;
        sbox_in3    = '0;
        sbox_r      = '0;
        if (issue) begin
            sbox_in1 = sh1_q[issue_bit +: 4];
            sbox_in2 = sh2_q[issue_bit +: 4];
            sbox_in3 = sh3_q[issue_bit +: 4];
            sbox_r   = rnd;
        end
    end

    assign sbox_klmn_in1 = klmn_fb[3:0];
    assign sbox_klmn_in2 = klmn_fb;
    assign sh1_out       = res1;
    assign sh2_out       = res2;
    assign sh3_out       = res3;

    // The tag pipe never stalls: bubbles travel through it as invalid slots.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh1_q     <= '0;
            sh2_q     <= '0;
            sh3_q     <= '0;
            res1      <= '0;
            res2      <= '0;
            res3      <= '0;
            issue_cnt <= '0;
            col_cnt   <= '0;
            klmn_fb   <= '0;
            tag_v     <= '0;
            tag_idx   <= '0;
        end else begin
            tag_v[1]   <= issue;
            tag_idx[1] <= issue_cnt[IW-1:0];
            for (int k = 2; k <= LAT; k++) begin
                tag_v[k]   <= tag_v[k-1];
                tag_idx[k] <= tag_idx[k-1];
            end
            if (start_acc) begin
                sh1_q     <= sh1_in;
                sh2_q     <= sh2_in;
                sh3_q     <= sh3_in;
                issue_cnt <= '0;
                col_cnt   <= '0;
                klmn_fb   <= '0;
            end else begin
                if (issue) issue_cnt <= issue_cnt + 5'd1;
                if (collect && (col_cnt != 5'(NNIB))) col_cnt <= col_cnt + 5'd1;
                if (tag_v[1]) klmn_fb <= sbox_klmn_out1;
            end
            if (collect) begin
                res1[col_bit +: 4] <= sbox_out1;
                res2[col_bit +: 4] <= sbox_out2;
                res3[col_bit +: 4] <= sbox_out3;
            end
        end
    end
endmodule

// File: tb/tb_prince_sbox_inv_ctrl.sv
// Directed bench for prince_sbox_inv_ctrl with a behavioural LAT-deep masked
// inverse S-box attached to the S-box port.
module tb_prince_sbox_inv_ctrl;
    localparam int LAT = 4;

    localparam logic [63:0] XA   = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] RA   = 64'hB732_FD89_A640_5EC1;
    localparam logic [63:0] R1A  = 64'h48CD_0276_59BF_A13E;
    localparam logic [63:0] XB   = 64'hFEDC_BA98_7654_3210;
    localparam logic [63:0] RB   = 64'h1CE5_046A_98DF_237B;
    localparam logic [63:0] R1B  = 64'hE31A_FB95_6720_DC84;
    localparam logic [63:0] SH2E = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] SH3E = 64'hFEDC_BA98_7654_3210;
    localparam logic [63:0] MA2  = 64'h1111_2222_3333_4444;
    localparam logic [63:0] MA3  = 64'hA5A5_0F0F_F0F0_5A5A;
    localparam logic [63:0] MD2  = 64'h0F1E_2D3C_4B5A_6978;
    localparam logic [63:0] MD3  = 64'hC3C3_3C3C_9696_6969;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_valid = 1'b0;
    logic        start_ready;
    logic [63:0] sh1_in = '0, sh2_in = '0, sh3_in = '0;
    logic        rnd_valid = 1'b0;
    logic        rnd_ready;
    logic [42:0] rnd;
    logic [3:0]  sbox_in1, sbox_in2, sbox_in3;
    logic [42:0] sbox_r;
    logic [3:0]  sbox_klmn_in1;
    logic [5:0]  sbox_klmn_in2;
    logic [5:0]  sbox_klmn_out1;
    logic [3:0]  sbox_out1, sbox_out2, sbox_out3;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] sh1_out, sh2_out, sh3_out;
    logic        busy;

    int vectors     = 0;
    int miscompares = 0;
    int rnd_cnt     = 0;
    logic [5:0]  exp_klmn = '0;
    logic [63:0] exp_s1 = '0, exp_s2 = '0, exp_s3 = '0;

    logic [LAT:1]       pv = '0;
    logic [LAT:1][11:0] pd = '0;
    logic [5:0]         pk1 = '0;
    logic               issue_obs;
    logic [3:0]         sbox_x;

    prince_sbox_inv_ctrl #(.LAT(LAT), .NNIB(16)) dut (
        .clk(clk), .rst(rst),
        .start_valid(start_valid), .start_ready(start_ready),
        .sh1_in(sh1_in), .sh2_in(sh2_in), .sh3_in(sh3_in),
        .rnd_valid(rnd_valid), .rnd_ready(rnd_ready), .rnd(rnd),
        .sbox_in1(sbox_in1), .sbox_in2(sbox_in2), .sbox_in3(sbox_in3),
        .sbox_r(sbox_r),
        .sbox_klmn_in1(sbox_klmn_in1), .sbox_klmn_in2(sbox_klmn_in2),
        .sbox_klmn_out1(sbox_klmn_out1),
        .sbox_out1(sbox_out1), .sbox_out2(sbox_out2), .sbox_out3(sbox_out3),
        .out_valid(out_valid), .out_ready(out_ready),
        .sh1_out(sh1_out), .sh2_out(sh2_out), .sh3_out(sh3_out),
        .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] sbox_inv(input logic [3:0] x);
        case (x)
            4'h0: return 4'hB;  4'h1: return 4'h7;  4'h2: return 4'h3;  4'h3: return 4'h2;
            4'h4: return 4'hF;  4'h5: return 4'hD;  4'h6: return 4'h8;  4'h7: return 4'h9;
            4'h8: return 4'hA;  4'h9: return 4'h6;  4'hA: return 4'h4;  4'hB: return 4'h0;
            4'hC: return 4'h5;  4'hD: return 4'hE;  4'hE: return 4'hC;  default: return 4'h1;
        endcase
    endfunction

    // Word k carries masks ~k and k in its low byte; bubbles present junk.
    assign rnd = rnd_valid ? {35'h5A5A5A5A5 ^ 35'(rnd_cnt), 4'(rnd_cnt), ~4'(rnd_cnt)}
                           : {3'b101, 40'h55_5555_5555};
    assign issue_obs = rnd_valid && rnd_ready;
    assign sbox_x    = sbox_in1 ^ sbox_in2 ^ sbox_in3;

    assign sbox_out1      = pv[LAT] ? pd[LAT][11:8] : 4'h6;
    assign sbox_out2      = pv[LAT] ? pd[LAT][7:4]  : 4'h6;
    assign sbox_out3      = pv[LAT] ? pd[LAT][3:0]  : 4'h6;
    assign sbox_klmn_out1 = pv[1]   ? pk1           : 6'h2A;

    always @(posedge clk) begin
        pv  <= {pv[LAT-1:1], issue_obs};
        pd  <= {pd[LAT-1:1], {sbox_inv(sbox_x) ^ sbox_r[3:0] ^ sbox_r[7:4], sbox_r[3:0], sbox_r[7:4]}};
        pk1 <= {sbox_x[1:0] ^ 2'b11, sbox_inv(sbox_x)} ^ sbox_klmn_in2;
        if (start_valid && start_ready) begin
            rnd_cnt  <= 0;
            exp_klmn <= '0;
        end else begin
            if (issue_obs) rnd_cnt <= rnd_cnt + 1;
            if (pv[1]) exp_klmn <= pk1;
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    always @(negedge clk) begin
        if (issue_obs) begin
            checkOutput("sbox_in1", sbox_in1, exp_s1[rnd_cnt*4 +: 4]);
            checkOutput("sbox_in2", sbox_in2, exp_s2[rnd_cnt*4 +: 4]);
            checkOutput("sbox_in3", sbox_in3, exp_s3[rnd_cnt*4 +: 4]);
            checkOutput("sbox_r", sbox_r, rnd);
            if (rnd_cnt == 0) checkOutput("klmn_nib0", sbox_klmn_in2, 6'd0);
            else              checkOutput("klmn_chain", sbox_klmn_in2, exp_klmn);
            checkOutput("klmn_in1", sbox_klmn_in1, exp_klmn[3:0]);
        end else begin
            checkOutput("quiet_sbox_in", {sbox_in1, sbox_in2, sbox_in3}, 12'h0);
            checkOutput("quiet_sbox_r", sbox_r, 43'h0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkShares(input logic [63:0] e1, input logic [63:0] e2,
                               input logic [63:0] e3, input logic [63:0] ex);
        checkOutput("sh1_out", sh1_out, e1);
        checkOutput("sh2_out", sh2_out, e2);
        checkOutput("sh3_out", sh3_out, e3);
        checkOutput("sh_xor", sh1_out ^ sh2_out ^ sh3_out, ex);
    endtask

    // Cycle 0 is the start-accept cycle; returns the cycle out_valid was seen.
    task automatic applyStimulus(input logic [63:0] s1, input logic [63:0] s2, input logic [63:0] s3,
                                 input int bub_a, input int bub_b, input int bub_c,
                                 input int pulse_cyc, input int rst_cyc, output int done_cyc);
        int  c;
        bit  stop;
        exp_s1 = s1;
        exp_s2 = s2;
        exp_s3 = s3;
        sh1_in = s1;
        sh2_in = s2;
        sh3_in = s3;
        checkOutput("start_ready_idle", start_ready, 1'b1);
        start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
        sh1_in = ~s1;
        sh2_in = ~s2;
        sh3_in = ~s3;
        done_cyc = -1;
        stop = 1'b0;
        c = 1;
        while (!stop && c < 100) begin
            if (out_valid) begin
                done_cyc = c;
                stop = 1'b1;
            end else if (c == rst_cyc) begin
                rnd_valid = 1'b0;
                rst = 1'b1;
                stop = 1'b1;
            end else begin
                rnd_valid   = !(c == bub_a || c == bub_b || c == bub_c);
                start_valid = (c == pulse_cyc);
                if (c == pulse_cyc) begin
                    sh1_in = 64'hFFFF_0000_FFFF_0000;
                    checkOutput("start_ignored", {busy, start_ready}, 2'b10);
                end
                tick();
                c++;
            end
        end
        start_valid = 1'b0;
        rnd_valid   = 1'b0;
        if (done_cyc < 0 && rst_cyc < 0) checkOutput("out_valid_timeout", out_valid, 1'b1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int done_cyc;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checkOutput("rst_flags", {start_ready, rnd_ready, out_valid, busy}, 4'b1000);
        checkShares(64'h0, 64'h0, 64'h0, 64'h0);
        checkOutput("rst_klmn", {sbox_klmn_in1, sbox_klmn_in2}, 10'h0);

        applyStimulus(XA, 64'h0, 64'h0, -1, -1, -1, -1, -1, done_cyc);
        checkOutput("latency_a", done_cyc, 21);
        checkShares(R1A, SH2E, SH3E, RA);
        checkOutput("rnd_words_a", rnd_cnt, 16);
        tick();
        checkOutput("idle_after_a", {start_ready, out_valid, busy}, 3'b100);

        applyStimulus(XA ^ MA2 ^ MA3, MA2, MA3, 3, 4, 10, 6, -1, done_cyc);
        checkOutput("latency_b", done_cyc, 24);
        checkShares(R1A, SH2E, SH3E, RA);
        checkOutput("rnd_words_b", rnd_cnt, 16);
        tick();
        checkOutput("idle_after_b", {start_ready, out_valid, busy}, 3'b100);

        applyStimulus(XB ^ MD2 ^ MD3, MD2, MD3, -1, -1, -1, -1, 8, done_cyc);
        tick();
        checkOutput("abort_flags", {start_ready, rnd_ready, out_valid, busy}, 4'b1000);
        checkShares(64'h0, 64'h0, 64'h0, 64'h0);
        checkOutput("abort_klmn", sbox_klmn_in2, 6'h0);
        rst = 1'b0;
        repeat (LAT + 2) tick();
        checkShares(64'h0, 64'h0, 64'h0, 64'h0);
        checkOutput("abort_idle", {start_ready, busy}, 2'b10);

        out_ready = 1'b0;
        applyStimulus(XB ^ MD2 ^ MD3, MD2, MD3, -1, -1, -1, -1, -1, done_cyc);
        checkOutput("latency_d", done_cyc, 21);
        for (int k = 0; k < 5; k++) begin
            checkOutput("hold_valid", out_valid, 1'b1);
            checkOutput("hold_start_ready", start_ready, 1'b0);
            checkShares(R1B, SH2E, SH3E, RB);
            tick();
        end
        out_ready = 1'b1;
        checkOutput("done_valid", out_valid, 1'b1);
        tick();
        checkOutput("idle_after_d", {start_ready, out_valid, busy}, 3'b100);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
